// File: rtl/wdt_pkg.sv
// wdt_pkg: shared state encoding, mode constants and counter reset value for the watchdog.
package wdt_pkg;
    typedef enum logic [1:0] {RUN, WARN, EXPIRED} wdt_state_e;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_WARN   = 1'b1;
    function automatic logic [31:0] cnt_rst_val(int unsigned w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction
endpackage

// File: rtl/wdt_multi_chan_if.sv
// wdt_multi_chan_if: per-channel control inputs and status outputs of the watchdog bank.
// WDT_WINDOW_EN adds the window input and early_err output.
interface wdt_multi_chan_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH-1:0]       kick;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*CNT_W-1:0] start_value;
    logic [NUM_CH-1:0]       timeout;
    logic [NUM_CH-1:0]       irq;
    logic                    timeout_any;
    logic                    irq_any;
`ifdef WDT_WINDOW_EN
    logic [NUM_CH*CNT_W-1:0] window;
    logic [NUM_CH-1:0]       early_err;
    modport master (output enable, mode, kick, load, start_value, window,
                    input timeout, irq, timeout_any, irq_any, early_err);
    modport slave  (input enable, mode, kick, load, start_value, window,
                    output timeout, irq, timeout_any, irq_any, early_err);
`else
    modport master (output enable, mode, kick, load, start_value,
                    input timeout, irq, timeout_any, irq_any);
    modport slave  (input enable, mode, kick, load, start_value,
                    output timeout, irq, timeout_any, irq_any);
`endif
endinterface

// File: rtl/wdt_chan.sv
// wdt_chan: one down-counting watchdog channel with optional warning expiries before timeout.
// WDT_WINDOW_EN rejects kicks arriving while the count is still above the window.
module wdt_chan
    import wdt_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WARN_MAX = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             mode_i,
    input  logic             kick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] start_value_i,
`ifdef WDT_WINDOW_EN
    input  logic [CNT_W-1:0] window_i,
    output logic             early_err_o,
`endif
    output logic             timeout_o,
    output logic             irq_o
);
    localparam int WW = $clog2(WARN_MAX + 1);

    wdt_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic [WW-1:0]    warn_q;
    logic             mode_q;
    logic             timeout_q;
    logic             irq_q;
    logic             early_q;
    logic             early_kick;

`ifdef WDT_WINDOW_EN
    assign early_kick  = state_q != EXPIRED && count_q > window_i;
    assign early_err_o = early_q;
`else
    assign early_kick = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            count_q   <= CNT_W'(cnt_rst_val(CNT_W));
            warn_q    <= '0;
            mode_q    <= MODE_DIRECT;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
            early_q   <= 1'b0;
        end else if (mode_i != mode_q || (kick_i && !early_kick)) begin
            // mode change and an accepted kick both restart the channel from scratch
            mode_q    <= mode_i;
            state_q   <= RUN;
            count_q   <= start_value_i;
            warn_q    <= '0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
            early_q   <= 1'b0;
        end else if (kick_i) begin
            state_q   <= EXPIRED;
            timeout_q <= 1'b1;
            early_q   <= 1'b1;
        end else if (load_i) begin
            count_q <= start_value_i;
        end else if (enable_i && state_q != EXPIRED) begin
            if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end else begin
                count_q <= start_value_i;
                if (mode_q == MODE_WARN && warn_q < WW'(WARN_MAX)) begin
                    state_q <= WARN;
                    irq_q   <= 1'b1;
                    warn_q  <= warn_q + 1'b1;
                end else begin
                    state_q   <= EXPIRED;
                    timeout_q <= 1'b1;
                    irq_q     <= 1'b0;
                end
            end
        end
    end

    assign timeout_o = timeout_q;
    assign irq_o     = irq_q;
endmodule

// File: rtl/wdt_multi_chan.sv
// wdt_multi_chan: bank of NUM_CH independent watchdog channels with registered OR summaries.
// WDT_WINDOW_EN enables windowed (early-kick) detection per channel.
module wdt_multi_chan #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int WARN_MAX = 1
) (
    input logic              clk,
    input logic              rst_n,
    wdt_multi_chan_if.slave  bus
);
    logic [NUM_CH-1:0] timeout_w;
    logic [NUM_CH-1:0] irq_w;
    logic              timeout_any_q;
    logic              irq_any_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        wdt_chan #(
            .CNT_W   (CNT_W),
            .WARN_MAX(WARN_MAX)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .enable_i     (bus.enable[i]),
            .mode_i       (bus.mode[i]),
            .kick_i       (bus.kick[i]),
            .load_i       (bus.load[i]),
            .start_value_i(bus.start_value[i*CNT_W +: CNT_W]),
`ifdef WDT_WINDOW_EN
            .window_i     (bus.window[i*CNT_W +: CNT_W]),
            .early_err_o  (bus.early_err[i]),
`endif
            .timeout_o    (timeout_w[i]),
            .irq_o        (irq_w[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_any_q <= 1'b0;
            irq_any_q     <= 1'b0;
        end else begin
            timeout_any_q <= |timeout_w;
            irq_any_q     <= |irq_w;
        end
    end

    assign bus.timeout     = timeout_w;
    assign bus.irq         = irq_w;
    assign bus.timeout_any = timeout_any_q;
    assign bus.irq_any     = irq_any_q;
endmodule

// File: doc/wdt_multi_chan.md
Name: wdt_multi_chan

Overview:
Next-generation watchdog: NUM_CH independent down-counting watchdog channels with parametrised counter width and a configurable number of warning interrupts before timeout. Sits beside the system control block; software or a supervisor FSM kicks each channel. Per-channel timeout/irq outputs plus OR-reduced summaries feed the reset controller and the interrupt aggregator.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
CNT_W, 32, counter width per channel (8..32)
WARN_MAX, 1, warning expiries in mode 1 before timeout (1..7); warn counter width = $clog2(WARN_MAX+1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_  in  1  asynchronous active-low reset
enable  in  NUM_CH  per-channel count enable; low = pause (count and outputs hold)
mode  in  NUM_CH  0 = direct timeout, 1 = warn-then-timeout
kick  in  NUM_CH  service pulse; reload and clear warnings
load  in  NUM_CH  reload counter only; warnings, irq and timeout unchanged
start_value  in  NUM_CH*CNT_W  reload value, channel i at [i*CNT_W +: CNT_W]
timeout  out  NUM_CH  sticky timeout per channel
irq  out  NUM_CH  warning interrupt per channel, level
timeout_any  out  1  OR of timeout
irq_any  out  1  OR of irq

Behaviour:
- Reset: count = all ones, timeout = 0, irq = 0, warn_cnt = 0, mode_q = 0, state RUN. All outputs registered; summaries are registered ORs (1 cycle after the per-channel bit).
- States per channel: RUN (counting, no warning), WARN (irq high, counting), EXPIRED (timeout high, counter holds).
- Per-channel priority per cycle, highest first: mode change (mode != mode_q) > kick > load > enable count.
- Mode change: mode_q <= mode, count <= start_value, timeout <= 0, irq <= 0, warn_cnt <= 0, state RUN. Overrides a simultaneous kick/load.
- Kick (any state): count <= start_value, irq <= 0, warn_cnt <= 0, timeout <= 0, state RUN. Kicks are honoured even when enable = 0.
- Load: count <= start_value only; state unchanged.
- enable = 1, state RUN/WARN, count != 0: count <= count - 1.
- enable = 1, count == 0: count <= start_value, then:
  mode_q 0: timeout <= 1, state EXPIRED.
  mode_q 1, warn_cnt < WARN_MAX: irq <= 1, warn_cnt++, state WARN.
  mode_q 1, warn_cnt == WARN_MAX: timeout <= 1, irq <= 0, state EXPIRED.
- Expiry period = start_value + 1 enabled cycles. start_value = 0 expires on every enabled cycle.
- EXPIRED: counter holds, timeout stays high until kick, mode change or reset; enable has no effect.
- Channels are fully independent; no shared arithmetic. No wrap-around, since decrement never goes below 0.

Optional Feature:
WDT_WINDOW_EN: adds input window (NUM_CH*CNT_W) and output early_err (NUM_CH, sticky, reset 0).
- A kick while count > window[i] in RUN/WARN is early: early_err <= 1, timeout <= 1, state EXPIRED, no reload.
- A kick in EXPIRED is never early.
- early_err is cleared by the next accepted kick or by mode change.
- Without the macro: no window/early_err ports; every kick is accepted.

Decomposition:
- Package wdt_pkg: state enum (RUN, WARN, EXPIRED), mode constants MODE_DIRECT = 0, MODE_WARN = 1, counter reset value function.
- Sub-module wdt_chan: one channel FSM plus counter, parametrised by CNT_W and WARN_MAX.
- Top generate-loops NUM_CH instances, slices start_value/window and registers the OR summaries.

Test Plan:
- Channel 0 setup: mode 0, start_value = 5, enable from cycle 0, no kick -> timeout[0] rises at cycle 6 and timeout_any at cycle 7; timeout stays high for 20 more cycles; kick clears it the next cycle.
- Mode 1, WARN_MAX = 2, start_value = 3 -> irq rises at cycle 4; second expiry at cycle 8 keeps irq high; timeout rises at cycle 12 with irq falling the same cycle.
- Mode 1, start_value = 3, kick at cycle 6 -> irq falls at cycle 7, warn_cnt reset, next irq at cycle 11.
- Mode toggled in the same cycle as a kick, with timeout high -> timeout clears, count = start_value, mode_q follows mode; enable = 0 for 10 cycles holds count exactly.
- NUM_CH = 4 with channels at start_value 2/4/6/8 in mode 0 -> timeout bits rise at cycles 3/5/7/9 independently; load on channel 2 at cycle 4 delays only that channel to cycle 11.
- WDT_WINDOW_EN: start_value = 10, window = 4, kick when count = 7 -> early_err and timeout set next cycle; a kick when count = 3 is accepted, reloads to 10 and leaves early_err at 0.
